// File: rtl/write_violation_logger.sv
// Logs unauthorized memory writes into a small FIFO for firmware, keeps a saturating
// violation total, and runs a windowed rate-based alert/lock FSM.
module write_violation_logger #(
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned THRESH = 3,
   parameter int unsigned WINDOW = 16
) (
   input  logic                    wb_clk_i,
   input  logic                    rstb,
   input  logic                    evt_valid,
   input  logic                    evt_unauth,
   input  logic [3:0]              evt_addr,
   input  logic [3:0]              evt_data,
   input  logic [1:0]              evt_id,
   input  logic                    rd_req,
   input  logic                    clr_lock,
   output logic                    rd_valid,
   output logic [9:0]              rd_entry,
   output logic [$clog2(DEPTH):0]  log_count,
   output logic                    log_empty,
   output logic                    log_full,
   output logic                    overflow,
   output logic [7:0]              viol_total,
   output logic                    alert,
   output logic                    lock
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;
   localparam logic [CW-1:0] FullCnt   = CW'(DEPTH);
   localparam logic [8:0]    ThreshW   = 9'(THRESH);
   localparam logic [7:0]    TimerInit = 8'(WINDOW - 1);

   localparam logic [1:0] StIdle   = 2'd0;
   localparam logic [1:0] StAlert  = 2'd1;
   localparam logic [1:0] StLocked = 2'd2;

   logic [9:0]    mem [DEPTH];
   logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;
   logic          empty_q, full_q;
   logic          rd_valid_q;
   logic [9:0]    rd_entry_q, rd_entry_d;
   logic          overflow_q, overflow_d;
   logic [7:0]    total_q, total_d;
   logic [1:0]    state_q, state_d;
   logic [7:0]    win_cnt_q, win_cnt_d;
   logic [7:0]    timer_q, timer_d;

   logic viol, pop, push, drop;
   logic [7:0] win_inc;

   assign viol = evt_valid & evt_unauth;
   assign pop  = rd_req & (count_q != '0);
   // A pop in the same cycle frees a slot, so a full log still accepts the push.
   assign push = viol & ((count_q != FullCnt) | pop);
   assign drop = viol & ~push;

   always_comb begin
      wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d   = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
      rd_entry_d = pop ? mem[rd_ptr_q] : rd_entry_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + CW'(1);
      end else if (pop && !push) begin
         count_d = count_q - CW'(1);
      end
   end

   always_comb begin
      overflow_d = overflow_q;
      if (clr_lock) overflow_d = 1'b0;
      if (drop) overflow_d = 1'b1;
      total_d = (viol && total_q != 8'hFF) ? total_q + 8'd1 : total_q;
   end

   assign win_inc = (win_cnt_q == 8'hFF) ? win_cnt_q : win_cnt_q + 8'd1;

   always_comb begin
      state_d   = state_q;
      win_cnt_d = win_cnt_q;
      timer_d   = timer_q;
      if (clr_lock) begin
         // clr_lock dominates; a coincident violation opens a fresh window.
         if (viol) begin
            state_d   = StAlert;
            win_cnt_d = 8'd1;
            timer_d   = TimerInit;
         end else begin
            state_d   = StIdle;
            win_cnt_d = 8'd0;
         end
      end else begin
         unique case (state_q)
            StIdle: begin
               if (viol) begin
                  win_cnt_d = 8'd1;
                  timer_d   = TimerInit;
                  state_d   = (ThreshW == 9'd1) ? StLocked : StAlert;
               end
            end
            StAlert: begin
               if (viol && (({1'b0, win_cnt_q} + 9'd1) >= ThreshW)) begin
                  state_d = StLocked;
               end else if (timer_q == 8'd0) begin
                  if (viol) begin
                     state_d   = StAlert;
                     win_cnt_d = 8'd1;
                     timer_d   = TimerInit;
                  end else begin
                     state_d   = StIdle;
                     win_cnt_d = 8'd0;
                  end
               end else begin
                  timer_d = timer_q - 8'd1;
                  if (viol) win_cnt_d = win_inc;
               end
            end
            StLocked: begin
               state_d = StLocked;
            end
            default: begin
               state_d   = StIdle;
               win_cnt_d = 8'd0;
               timer_d   = 8'd0;
            end
         endcase
      end
   end

   // Log storage is not reset; the pointers and count define what is valid.
   always_ff @(posedge wb_clk_i) begin
      if (push) mem[wr_ptr_q] <= {evt_id, evt_addr, evt_data};
   end

   always_ff @(posedge wb_clk_i or negedge rstb) begin
      if (!rstb) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         empty_q    <= 1'b1;
         full_q     <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_entry_q <= '0;
         overflow_q <= 1'b0;
         total_q    <= '0;
         state_q    <= StIdle;
         win_cnt_q  <= '0;
         timer_q    <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         empty_q    <= (count_d == '0);
         full_q     <= (count_d == FullCnt);
         rd_valid_q <= pop;
         rd_entry_q <= rd_entry_d;
         overflow_q <= overflow_d;
         total_q    <= total_d;
         state_q    <= state_d;
         win_cnt_q  <= win_cnt_d;
         timer_q    <= timer_d;
      end
   end

   assign rd_valid   = rd_valid_q;
   assign rd_entry   = rd_entry_q;
   assign log_count  = count_q;
   assign log_empty  = empty_q;
   assign log_full   = full_q;
   assign overflow   = overflow_q;
   assign viol_total = total_q;
   assign alert      = (state_q == StAlert);
   assign lock       = (state_q == StLocked);

endmodule

// File: tb/tb_write_violation_logger.sv
// Bench for write_violation_logger: directed vector table, hand-written corner sequences
// and randomized traffic against a queue/deadline reference model.
module tb_write_violation_logger;

   localparam int unsigned DEPTH  = 4;
   localparam int unsigned THRESH = 3;
   localparam int unsigned WINDOW = 16;

   logic       clk = 1'b0;
   logic       rstb = 1'b1;
   logic       evt_valid = 1'b0, evt_unauth = 1'b0;
   logic [3:0] evt_addr = '0, evt_data = '0;
   logic [1:0] evt_id = '0;
   logic       rd_req = 1'b0, clr_lock = 1'b0;
   logic       rd_valid;
   logic [9:0] rd_entry;
   logic [2:0] log_count;
   logic       log_empty, log_full, overflow, alert, lock;
   logic [7:0] viol_total;

   int n_checks = 0;
   int n_errors = 0;

   write_violation_logger #(
      .DEPTH  (DEPTH),
      .THRESH (THRESH),
      .WINDOW (WINDOW)
   ) dut (
      .wb_clk_i   (clk),
      .rstb       (rstb),
      .evt_valid  (evt_valid),
      .evt_unauth (evt_unauth),
      .evt_addr   (evt_addr),
      .evt_data   (evt_data),
      .evt_id     (evt_id),
      .rd_req     (rd_req),
      .clr_lock   (clr_lock),
      .rd_valid   (rd_valid),
      .rd_entry   (rd_entry),
      .log_count  (log_count),
      .log_empty  (log_empty),
      .log_full   (log_full),
      .overflow   (overflow),
      .viol_total (viol_total),
      .alert      (alert),
      .lock       (lock)
   );

   always #5 clk = ~clk;

   // Reference model: log is a queue; the window is an absolute deadline cycle.
   logic [9:0] mq[$];
   bit         m_rdv, m_ovf;
   logic [9:0] m_entry;
   int         m_total, m_mode, m_cnt, m_deadline, m_cyc;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   task automatic model_reset();
      mq.delete();
      m_rdv = 0; m_ovf = 0; m_entry = '0;
      m_total = 0; m_mode = 0; m_cnt = 0; m_deadline = 0; m_cyc = 0;
   endtask

   task automatic model_step();
      bit viol, pop;
      viol = evt_valid & evt_unauth;
      pop  = rd_req && (mq.size() != 0);
      m_rdv = pop;
      if (pop) m_entry = mq.pop_front();
      if (clr_lock) m_ovf = 0;
      if (viol) begin
         if (mq.size() < DEPTH) mq.push_back({evt_id, evt_addr, evt_data});
         else m_ovf = 1;
      end
      if (viol && m_total < 255) m_total++;
      if (clr_lock) begin
         if (viol) begin m_mode = 1; m_cnt = 1; m_deadline = m_cyc + WINDOW; end
         else begin m_mode = 0; m_cnt = 0; end
      end else if (m_mode == 0) begin
         if (viol) begin
            m_cnt = 1; m_deadline = m_cyc + WINDOW;
            m_mode = (THRESH == 1) ? 2 : 1;
         end
      end else if (m_mode == 1) begin
         if (viol && m_cnt + 1 >= THRESH) m_mode = 2;
         else if (m_cyc == m_deadline) begin
            if (viol) begin m_cnt = 1; m_deadline = m_cyc + WINDOW; end
            else begin m_mode = 0; m_cnt = 0; end
         end else if (viol && m_cnt < 255) m_cnt++;
      end
      m_cyc++;
   endtask

   task automatic check_all();
      chk("rd_valid", rd_valid, m_rdv);
      chk("rd_entry", rd_entry, m_entry);
      chk("log_count", log_count, mq.size());
      chk("log_empty", log_empty, mq.size() == 0);
      chk("log_full", log_full, mq.size() == DEPTH);
      chk("overflow", overflow, m_ovf);
      chk("viol_total", viol_total, m_total);
      chk("alert", alert, m_mode == 1);
      chk("lock", lock, m_mode == 2);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic set_in(bit v, bit u, logic [1:0] id, logic [3:0] a, logic [3:0] d, bit rd,
                         bit clr);
      evt_valid = v; evt_unauth = u; evt_id = id; evt_addr = a; evt_data = d;
      rd_req = rd; clr_lock = clr;
   endtask

   task automatic idle(int n);
      set_in(0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic viol1(logic [1:0] id, logic [3:0] a, logic [3:0] d);
      set_in(1, 1, id, a, d, 0, 0);
      tick();
   endtask

   // Asserts reset between clock edges and checks outputs before any edge arrives.
   task automatic do_reset();
      rstb = 1'b0;
      #1;
      chk("rst_count", log_count, 0);
      chk("rst_empty", log_empty, 1);
      chk("rst_full", log_full, 0);
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_rd_entry", rd_entry, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_total", viol_total, 0);
      chk("rst_alert", alert, 0);
      chk("rst_lock", lock, 0);
      model_reset();
      set_in(0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rstb = 1'b1;
   endtask

   typedef struct {
      bit v, u; logic [1:0] id; logic [3:0] a, d; bit rd, clr;
      int cnt; bit rdv; logic [9:0] entry; bit ovf; int total; bit al, lk;
   } vec_t;

   function automatic vec_t mkv(bit v, bit u, logic [1:0] id, logic [3:0] a, logic [3:0] d,
                                bit rd, bit clr, int cnt, bit rdv, logic [9:0] entry, bit ovf,
                                int total, bit al, bit lk);
      vec_t r;
      r.v = v; r.u = u; r.id = id; r.a = a; r.d = d; r.rd = rd; r.clr = clr;
      r.cnt = cnt; r.rdv = rdv; r.entry = entry; r.ovf = ovf; r.total = total;
      r.al = al; r.lk = lk;
      return r;
   endfunction

   vec_t tbl[16];

   initial begin
      tbl[0]  = mkv(1, 1, 3, 4'hA, 4'hF, 0, 0, 1, 0, 10'h000, 0, 1, 1, 0);
      tbl[1]  = mkv(0, 0, 0, 0, 0,       1, 0, 0, 1, 10'h3AF, 0, 1, 1, 0);
      tbl[2]  = mkv(1, 0, 2, 5, 5,       0, 0, 0, 0, 10'h3AF, 0, 1, 1, 0);
      tbl[3]  = mkv(0, 0, 0, 0, 0,       0, 1, 0, 0, 10'h3AF, 0, 1, 0, 0);
      tbl[4]  = mkv(1, 1, 1, 1, 1,       0, 0, 1, 0, 10'h3AF, 0, 2, 1, 0);
      tbl[5]  = mkv(1, 1, 1, 2, 2,       0, 0, 2, 0, 10'h3AF, 0, 3, 1, 0);
      tbl[6]  = mkv(1, 1, 2, 3, 3,       0, 0, 3, 0, 10'h3AF, 0, 4, 0, 1);
      tbl[7]  = mkv(1, 1, 2, 4, 4,       0, 0, 4, 0, 10'h3AF, 0, 5, 0, 1);
      tbl[8]  = mkv(1, 1, 3, 5, 5,       0, 0, 4, 0, 10'h3AF, 1, 6, 0, 1);
      tbl[9]  = mkv(1, 1, 0, 6, 6,       1, 0, 4, 1, 10'h111, 1, 7, 0, 1);
      tbl[10] = mkv(0, 0, 0, 0, 0,       1, 0, 3, 1, 10'h122, 1, 7, 0, 1);
      tbl[11] = mkv(0, 0, 0, 0, 0,       1, 0, 2, 1, 10'h233, 1, 7, 0, 1);
      tbl[12] = mkv(0, 0, 0, 0, 0,       1, 0, 1, 1, 10'h244, 1, 7, 0, 1);
      tbl[13] = mkv(0, 0, 0, 0, 0,       1, 0, 0, 1, 10'h066, 1, 7, 0, 1);
      tbl[14] = mkv(0, 0, 0, 0, 0,       1, 0, 0, 0, 10'h066, 1, 7, 0, 1);
      tbl[15] = mkv(0, 0, 0, 0, 0,       0, 1, 0, 0, 10'h066, 0, 7, 0, 0);

      #2;
      do_reset();

      // Directed table: basic push/pop, overflow, full push+pop, drain order, clr_lock.
      for (int i = 0; i < 16; i++) begin
         set_in(tbl[i].v, tbl[i].u, tbl[i].id, tbl[i].a, tbl[i].d, tbl[i].rd, tbl[i].clr);
         tick();
         chk($sformatf("vec%0d_count", i), log_count, tbl[i].cnt);
         chk($sformatf("vec%0d_rd_valid", i), rd_valid, tbl[i].rdv);
         chk($sformatf("vec%0d_rd_entry", i), rd_entry, tbl[i].entry);
         chk($sformatf("vec%0d_overflow", i), overflow, tbl[i].ovf);
         chk($sformatf("vec%0d_total", i), viol_total, tbl[i].total);
         chk($sformatf("vec%0d_alert", i), alert, tbl[i].al);
         chk($sformatf("vec%0d_lock", i), lock, tbl[i].lk);
      end

      // Three violations inside one window lock; clr_lock releases without touching total.
      do_reset();
      viol1(0, 0, 0); idle(4);
      viol1(0, 1, 1); idle(3);
      viol1(0, 2, 2);
      chk("win_lock", lock, 1);
      set_in(0, 0, 0, 0, 0, 0, 1); tick();
      chk("clr_lock_lock", lock, 0);
      chk("clr_lock_alert", alert, 0);
      chk("clr_lock_total", viol_total, 3);

      // Window expiry at cycle 16, then a fresh window starting with a count of one.
      do_reset();
      viol1(1, 0, 0); idle(4);
      viol1(1, 1, 1); idle(10);
      chk("expiry_alert_c15", alert, 1);
      idle(1);
      chk("expiry_alert_c16", alert, 0);
      idle(3);
      viol1(1, 2, 2);
      chk("reenter_alert", alert, 1);
      viol1(1, 3, 3);
      chk("reenter_no_lock", lock, 0);

      // Violation landing exactly on the expiry cycle restarts the window.
      do_reset();
      viol1(2, 0, 0); idle(15);
      viol1(2, 1, 1);
      chk("expiry_viol_alert", alert, 1);
      viol1(2, 2, 2);
      chk("expiry_viol_no_lock", lock, 0);
      viol1(2, 3, 3);
      chk("expiry_viol_lock", lock, 1);

      // Full log with simultaneous push and pop.
      do_reset();
      for (int i = 0; i < 4; i++) viol1(2'(i), 4'(i), 4'(i + 8));
      chk("full_before", log_full, 1);
      set_in(1, 1, 3, 4'hE, 4'hE, 1, 0); tick();
      chk("full_pp_count", log_count, 4);
      chk("full_pp_overflow", overflow, 0);
      chk("full_pp_entry", rd_entry, 10'h008);

      // Asynchronous reset while holding three entries and locked.
      do_reset();
      for (int i = 0; i < 3; i++) viol1(1, 4'(i), 4'(i));
      chk("pre_rst_count", log_count, 3);
      chk("pre_rst_lock", lock, 1);
      do_reset();

      // Saturating total.
      for (int i = 0; i < 300; i++) viol1(2'(i), 4'(i), 4'(i >> 4));
      chk("total_sat", viol_total, 255);

      // Randomized traffic with varying violation density.
      do_reset();
      for (int blk = 0; blk < 25; blk++) begin
         int dens;
         dens = $urandom_range(0, 100);
         for (int i = 0; i < 100; i++) begin
            set_in($urandom_range(0, 99) < dens, $urandom_range(0, 3) != 0, 2'($urandom),
                   4'($urandom), 4'($urandom), $urandom_range(0, 2) == 0,
                   $urandom_range(0, 40) == 0);
            tick();
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
